// File: rtl/sort_mem_pkg.sv
// sort_mem_pkg: response codes, FSM encodings and address helper shared by the memory responder.
package sort_mem_pkg;
  localparam int CNT_W = 4;
  localparam logic RESP_OKAY = 1'b0;
  localparam logic RESP_ERROR = 1'b1;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_WAIT = 2'd1, R_RESP = 2'd2} rd_state_t;
  typedef enum logic [1:0] {W_COLLECT = 2'd0, W_COMMIT = 2'd1, W_RESP = 2'd2} wr_state_t;
  function automatic logic addr_ok(input int unsigned addr, input int unsigned depth);
    return addr < depth;
  endfunction
endpackage

// File: rtl/sort_mem_storage.sv
// sort_mem_storage: register-file memory with bus and backdoor write ports (bus wins) and two async read ports.
module sort_mem_storage
  import sort_mem_pkg::*;
#(
  parameter int ADDR_WDTH = 4,
  parameter int DATA_WDTH = 32,
  parameter int MEM_DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_bus_we,
  input  logic [ADDR_WDTH-1:0] i_bus_addr,
  input  logic [DATA_WDTH-1:0] i_bus_wdata,
  input  logic                 i_dbg_we,
  input  logic [ADDR_WDTH-1:0] i_dbg_addr,
  input  logic [DATA_WDTH-1:0] i_dbg_wdata,
  input  logic [ADDR_WDTH-1:0] i_rd_addr,
  output logic [DATA_WDTH-1:0] o_rd_data,
  output logic [DATA_WDTH-1:0] o_dbg_rdata
);
  logic [DATA_WDTH-1:0] r_mem [MEM_DEPTH];
  logic w_bus_ok, w_dbg_ok, w_rd_ok;
  assign w_bus_ok = addr_ok(32'(i_bus_addr), MEM_DEPTH);
  assign w_dbg_ok = addr_ok(32'(i_dbg_addr), MEM_DEPTH);
  assign w_rd_ok  = addr_ok(32'(i_rd_addr), MEM_DEPTH);
  // The bus assignment comes last so it overrides a same-address backdoor write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MEM_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (i_dbg_we && w_dbg_ok) r_mem[i_dbg_addr] <= i_dbg_wdata;
      if (i_bus_we && w_bus_ok) r_mem[i_bus_addr] <= i_bus_wdata;
    end
  end
  assign o_rd_data   = w_rd_ok  ? r_mem[i_rd_addr]  : '0;
  assign o_dbg_rdata = w_dbg_ok ? r_mem[i_dbg_addr] : '0;
endmodule

// File: rtl/sort_mem_responder.sv
// sort_mem_responder: five-channel memory responder with programmable read latency and a backdoor debug port.
module sort_mem_responder
  import sort_mem_pkg::*;
#(
  parameter int ADDR_WDTH = 4,
  parameter int DATA_WDTH = 32,
  parameter int RESP_WDTH = 1,
  parameter int MEM_DEPTH = 16,
  parameter int RD_LAT    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ar_valid,
  output logic                 ar_ready,
  input  logic [ADDR_WDTH-1:0] ar_address,
  output logic                 r_valid,
  input  logic                 r_ready,
  output logic [DATA_WDTH-1:0] r_data,
  output logic [RESP_WDTH-1:0] r_resp,
  input  logic                 aw_valid,
  output logic                 aw_ready,
  input  logic [ADDR_WDTH-1:0] aw_address,
  input  logic                 w_valid,
  output logic                 w_ready,
  input  logic [DATA_WDTH-1:0] w_data,
  output logic                 b_valid,
  input  logic                 b_ready,
  output logic [RESP_WDTH-1:0] b_resp,
  input  logic                 dbg_we,
  input  logic [ADDR_WDTH-1:0] dbg_addr,
  input  logic [DATA_WDTH-1:0] dbg_wdata,
  output logic [DATA_WDTH-1:0] dbg_rdata
);
  localparam logic [CNT_W-1:0] CNT_INIT = (RD_LAT == 0) ? '0 : CNT_W'(RD_LAT - 1);
  localparam logic [RESP_WDTH-1:0] R_OK = RESP_WDTH'(RESP_OKAY);
  localparam logic [RESP_WDTH-1:0] R_ERR = RESP_WDTH'(RESP_ERROR);
  if (MEM_DEPTH > 2 ** ADDR_WDTH) begin : g_depth_chk
    $error("MEM_DEPTH exceeds the address space");
  end
  rd_state_t r_rstate, w_rnext;
  wr_state_t r_wstate, w_wnext;
  logic [CNT_W-1:0]     r_rcnt;
  logic [ADDR_WDTH-1:0] r_araddr, r_awaddr, w_rd_addr;
  logic [DATA_WDTH-1:0] r_rdata, r_wdata, w_mem_rdata;
  logic [RESP_WDTH-1:0] r_rresp, r_bresp;
  logic r_aw_got, r_w_got;
  logic w_ar_hs, w_aw_hs, w_w_hs, w_rd_ok, w_wr_ok, w_commit;
  assign w_ar_hs   = ar_valid & ar_ready;
  assign w_aw_hs   = aw_valid & aw_ready;
  assign w_w_hs    = w_valid & w_ready;
  // With zero latency the sample happens on the handshake edge, before the address is latched.
  assign w_rd_addr = (r_rstate == R_IDLE) ? ar_address : r_araddr;
  assign w_rd_ok   = addr_ok(32'(w_rd_addr), MEM_DEPTH);
  assign w_wr_ok   = addr_ok(32'(r_awaddr), MEM_DEPTH);
  assign w_commit  = (r_wstate == W_COMMIT);
  sort_mem_storage #(
    .ADDR_WDTH(ADDR_WDTH),
    .DATA_WDTH(DATA_WDTH),
    .MEM_DEPTH(MEM_DEPTH)
  ) u_storage (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_bus_we    (w_commit),
    .i_bus_addr  (r_awaddr),
    .i_bus_wdata (r_wdata),
    .i_dbg_we    (dbg_we),
    .i_dbg_addr  (dbg_addr),
    .i_dbg_wdata (dbg_wdata),
    .i_rd_addr   (w_rd_addr),
    .o_rd_data   (w_mem_rdata),
    .o_dbg_rdata (dbg_rdata)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rstate <= R_IDLE;
      r_rcnt   <= '0;
      r_araddr <= '0;
      r_rdata  <= '0;
      r_rresp  <= '0;
    end else begin
      r_rstate <= w_rnext;
      if (w_ar_hs) begin
        r_araddr <= ar_address;
        r_rcnt   <= CNT_INIT;
      end else if (r_rstate == R_WAIT) begin
        r_rcnt <= r_rcnt - CNT_W'(1);
      end
      if (w_rnext == R_RESP && r_rstate != R_RESP) begin
        r_rdata <= w_mem_rdata;
        r_rresp <= w_rd_ok ? R_OK : R_ERR;
      end
    end
  end
  always_comb begin
    w_rnext = r_rstate;
    case (r_rstate)
      R_IDLE:  if (ar_valid) w_rnext = (RD_LAT == 0) ? R_RESP : R_WAIT;
      R_WAIT:  if (r_rcnt == '0) w_rnext = R_RESP;
      R_RESP:  if (r_ready) w_rnext = R_IDLE;
      default: w_rnext = R_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wstate <= W_COLLECT;
      r_aw_got <= 1'b0;
      r_w_got  <= 1'b0;
      r_awaddr <= '0;
      r_wdata  <= '0;
      r_bresp  <= '0;
    end else begin
      r_wstate <= w_wnext;
      if (w_aw_hs) begin
        r_aw_got <= 1'b1;
        r_awaddr <= aw_address;
      end
      if (w_w_hs) begin
        r_w_got <= 1'b1;
        r_wdata <= w_data;
      end
      if (w_commit) begin
        r_aw_got <= 1'b0;
        r_w_got  <= 1'b0;
        r_bresp  <= w_wr_ok ? R_OK : R_ERR;
      end
    end
  end
  always_comb begin
    w_wnext = r_wstate;
    case (r_wstate)
      W_COLLECT: if ((r_aw_got | w_aw_hs) & (r_w_got | w_w_hs)) w_wnext = W_COMMIT;
      W_COMMIT:  w_wnext = W_RESP;
      W_RESP:    if (b_ready) w_wnext = W_COLLECT;
      default:   w_wnext = W_COLLECT;
    endcase
  end
  always_comb begin
    ar_ready = (r_rstate == R_IDLE);
    r_valid  = (r_rstate == R_RESP);
    r_data   = r_rdata;
    r_resp   = r_rresp;
    aw_ready = (r_wstate == W_COLLECT) & ~r_aw_got;
    w_ready  = (r_wstate == W_COLLECT) & ~r_w_got;
    b_valid  = (r_wstate == W_RESP);
    b_resp   = r_bresp;
  end
endmodule

// File: tb/tb_sort_mem_responder.sv
// tb_sort_mem_responder: table, hand-written and randomized checks of two responder configurations against an array model.
module tb_sort_mem_responder;
  localparam int DEPTH = 12;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  logic ar_valid = 0, r_ready = 0, aw_valid = 0, w_valid = 0, b_ready = 0, dbg_we = 0;
  logic [3:0] ar_address = 0, aw_address = 0, dbg_addr = 0;
  logic [31:0] w_data = 0, dbg_wdata = 0;
  logic ar_ready, r_valid, aw_ready, w_ready, b_valid;
  logic [31:0] r_data, dbg_rdata;
  logic [0:0] r_resp, b_resp;
  logic z_ar_ready, z_r_valid, z_aw_ready, z_w_ready, z_b_valid;
  logic [31:0] z_r_data, z_dbg_rdata;
  logic [0:0] z_r_resp, z_b_resp;
  int errors = 0, checks = 0;
  logic [31:0] mem_m [16];
  logic [31:0] mem_z [16];

  sort_mem_responder #(.ADDR_WDTH(4), .DATA_WDTH(32), .RESP_WDTH(1), .MEM_DEPTH(DEPTH), .RD_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_address(ar_address),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_address(aw_address),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp),
    .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata));

  sort_mem_responder #(.ADDR_WDTH(4), .DATA_WDTH(32), .RESP_WDTH(1), .MEM_DEPTH(16), .RD_LAT(0)) dut_z (
    .clk(clk), .rst_n(rst_n), .ar_valid(ar_valid), .ar_ready(z_ar_ready), .ar_address(ar_address),
    .r_valid(z_r_valid), .r_ready(r_ready), .r_data(z_r_data), .r_resp(z_r_resp),
    .aw_valid(aw_valid), .aw_ready(z_aw_ready), .aw_address(aw_address),
    .w_valid(w_valid), .w_ready(z_w_ready), .w_data(w_data),
    .b_valid(z_b_valid), .b_ready(b_ready), .b_resp(z_b_resp),
    .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_rdata(z_dbg_rdata));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out", name);
  endtask

  function automatic void model_wr(input logic [3:0] a, input logic [31:0] d);
    if (int'(a) < DEPTH) mem_m[a] = d;
    mem_z[a] = d;
  endfunction

  function automatic void model_clr();
    for (int i = 0; i < 16; i++) begin
      mem_m[i] = '0;
      mem_z[i] = '0;
    end
  endfunction

  function automatic logic [31:0] exp_m(input logic [3:0] a);
    return (int'(a) < DEPTH) ? mem_m[a] : 32'h0;
  endfunction

  task automatic dbg_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    dbg_we = 1; dbg_addr = a; dbg_wdata = d;
    @(negedge clk);
    dbg_we = 0;
    model_wr(a, d);
  endtask

  task automatic do_read(input logic [3:0] a, input int hold, output logic [31:0] d, output logic resp,
                         output int lat, output logic [31:0] dz, output logic rz, output int latz);
    int n = 0;
    @(negedge clk);
    ar_valid = 1; ar_address = a;
    while (!ar_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) fail_now("ar_ready_wait");
    @(negedge clk);
    ar_valid = 0; ar_address = 4'($urandom);
    lat = 1; latz = 0;
    while (1) begin
      chk("ar_ready_busy", ar_ready, 0);
      if (z_r_valid && latz == 0) latz = lat;
      if (r_valid || lat >= 50) break;
      @(negedge clk);
      lat++;
    end
    if (!r_valid) fail_now("r_valid_wait");
    d = r_data; resp = r_resp; dz = z_r_data; rz = z_r_resp;
    for (int i = 0; i < hold; i++) begin
      ar_valid = 1; ar_address = 4'($urandom);
      @(negedge clk);
      chk("r_valid_hold", r_valid, 1);
      chk("r_data_stable", r_data, d);
      chk("r_resp_stable", r_resp, resp);
      chk("ar_ready_hold", ar_ready, 0);
    end
    ar_valid = 0; r_ready = 1;
    @(negedge clk);
    r_ready = 0;
    chk("r_valid_drop", r_valid, 0);
    chk("ar_ready_back", ar_ready, 1);
  endtask

  task automatic do_write(input logic [3:0] a, input logic [31:0] d, input int t_aw, input int t_w,
                          input int hold, output logic resp, output logic rz);
    bit aw_p = 0, w_p = 0, aw_d = 0, w_d = 0;
    int c = 0, n = 0;
    while (!(aw_d && w_d) && c < 50) begin
      @(negedge clk);
      if (aw_p) begin aw_valid = 0; aw_d = 1; end
      if (w_p) begin w_valid = 0; w_d = 1; end
      if (aw_d && !w_d) begin
        chk("aw_ready_low", aw_ready, 0);
        aw_valid = 1'($urandom); aw_address = 4'($urandom);
      end
      if (w_d && !aw_d) begin
        chk("w_ready_low", w_ready, 0);
        w_valid = 1'($urandom); w_data = $urandom;
      end
      if (!aw_d && c >= t_aw) begin aw_valid = 1; aw_address = a; end
      if (!w_d && c >= t_w) begin w_valid = 1; w_data = d; end
      aw_p = !aw_d && aw_valid && aw_ready;
      w_p = !w_d && w_valid && w_ready;
      c++;
    end
    aw_valid = 0; w_valid = 0;
    if (c >= 50) fail_now("aw_w_accept");
    @(negedge clk);
    n = 1;
    while (!b_valid && n < 50) begin @(negedge clk); n++; end
    if (!b_valid) fail_now("b_valid_wait");
    chk("b_latency", n, 1);
    resp = b_resp; rz = z_b_resp;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("b_valid_hold", b_valid, 1);
      chk("b_resp_stable", b_resp, resp);
    end
    b_ready = 1;
    @(negedge clk);
    b_ready = 0;
    chk("b_valid_drop", b_valid, 0);
    chk("aw_ready_back", aw_ready, 1);
    chk("w_ready_back", w_ready, 1);
  endtask

  task automatic check_read(input logic [3:0] a, input int hold);
    logic [31:0] d, dz;
    logic r, rz;
    int l, lz;
    do_read(a, hold, d, r, l, dz, rz, lz);
    chk("rd_data", d, exp_m(a));
    chk("rd_resp", r, int'(a) >= DEPTH);
    chk("rd_lat", l, 2);
    chk("z_rd_data", dz, mem_z[a]);
    chk("z_rd_resp", rz, 0);
    chk("z_rd_lat", lz, 1);
  endtask

  task automatic check_write(input logic [3:0] a, input logic [31:0] d, input int t_aw, input int t_w, input int hold);
    logic r, rz;
    do_write(a, d, t_aw, t_w, hold, r, rz);
    chk("wr_resp", r, int'(a) >= DEPTH);
    chk("z_wr_resp", rz, 0);
    model_wr(a, d);
    dbg_addr = a;
    #1;
    chk("wr_mem", dbg_rdata, exp_m(a));
    chk("z_wr_mem", z_dbg_rdata, mem_z[a]);
  endtask

  typedef struct {
    bit          wr;
    logic [3:0]  a;
    logic [31:0] d;
    logic [31:0] exp_d;
    logic        exp_r;
  } vec_t;
  vec_t tbl [8];

  initial begin
    logic [31:0] d1, dz1, rd;
    logic r1, rz1, b1, bz1;
    int l1, lz1, op;
    logic [3:0] ra;
    model_clr();
    repeat (3) @(negedge clk);
    chk("rst_ar_ready", ar_ready, 1);
    chk("rst_aw_ready", aw_ready, 1);
    chk("rst_w_ready", w_ready, 1);
    chk("rst_r_valid", r_valid, 0);
    chk("rst_b_valid", b_valid, 0);
    chk("rst_r_data", r_data, 0);
    chk("rst_r_resp", r_resp, 0);
    chk("rst_b_resp", b_resp, 0);
    rst_n = 1;

    dbg_write(4'd3, 32'h0000_00A5);
    dbg_addr = 3; #1;
    chk("dbg_preload", dbg_rdata, 32'hA5);
    check_read(4'd3, 0);
    check_write(4'd5, 32'hDEAD_BEEF, 2, 0, 3);
    chk("dbg_after_commit", dbg_rdata, 32'hDEAD_BEEF);

    tbl[0] = '{1, 4'd1, 32'h100, 32'h0, 1'b0};
    tbl[1] = '{1, 4'd11, 32'hCAFE, 32'h0, 1'b0};
    tbl[2] = '{1, 4'd13, 32'h777, 32'h0, 1'b1};
    tbl[3] = '{0, 4'd1, 32'h0, 32'h100, 1'b0};
    tbl[4] = '{0, 4'd11, 32'h0, 32'hCAFE, 1'b0};
    tbl[5] = '{0, 4'd13, 32'h0, 32'h0, 1'b1};
    tbl[6] = '{0, 4'd3, 32'h0, 32'hA5, 1'b0};
    tbl[7] = '{0, 4'd0, 32'h0, 32'h0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      if (tbl[i].wr) begin
        do_write(tbl[i].a, tbl[i].d, i % 3, (i + 1) % 3, 0, b1, bz1);
        chk("tbl_wr_resp", b1, tbl[i].exp_r);
        model_wr(tbl[i].a, tbl[i].d);
      end else begin
        do_read(tbl[i].a, 0, d1, r1, l1, dz1, rz1, lz1);
        chk("tbl_rd_data", d1, tbl[i].exp_d);
        chk("tbl_rd_resp", r1, tbl[i].exp_r);
      end
    end
    dbg_addr = 13; #1;
    chk("oor_write_no_effect", dbg_rdata, 0);
    chk("z_addr13_written", z_dbg_rdata, 32'h777);

    check_read(4'd14, 4);

    @(negedge clk);
    aw_valid = 1; w_valid = 1; aw_address = 9; w_data = 32'h55;
    @(negedge clk);
    aw_valid = 0; w_valid = 0; dbg_we = 1; dbg_addr = 9; dbg_wdata = 32'h66;
    @(negedge clk);
    dbg_we = 0;
    chk("bus_dbg_b_valid", b_valid, 1);
    chk("bus_beats_dbg", dbg_rdata, 32'h55);
    chk("z_bus_beats_dbg", z_dbg_rdata, 32'h55);
    b_ready = 1;
    @(negedge clk);
    b_ready = 0;
    model_wr(4'd9, 32'h55);

    dbg_write(4'd14, 32'h1234);
    dbg_addr = 14; #1;
    chk("dbg_oor_ignored", dbg_rdata, 0);
    chk("z_dbg_full_range", z_dbg_rdata, 32'h1234);

    dbg_write(4'd7, 32'h11);
    fork
      do_read(4'd7, 0, d1, r1, l1, dz1, rz1, lz1);
      do_write(4'd7, 32'h22, 0, 0, 0, b1, bz1);
    join
    chk("collide_old_data", d1, 32'h11);
    chk("z_collide_old_data", dz1, 32'h11);
    chk("collide_wr_resp", b1, 0);
    model_wr(4'd7, 32'h22);
    check_read(4'd7, 0);

    for (int i = 0; i < 150; i++) begin
      op = $urandom_range(0, 3);
      ra = 4'($urandom);
      if (op < 2) check_read(ra, $urandom_range(0, 2));
      else if (op == 2) check_write(ra, $urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
      else begin
        rd = $urandom;
        dbg_write(ra, rd);
        dbg_addr = 4'($urandom); #1;
        chk("rand_dbg_rdata", dbg_rdata, exp_m(dbg_addr));
        chk("rand_z_dbg_rdata", z_dbg_rdata, mem_z[dbg_addr]);
      end
    end

    @(negedge clk);
    aw_valid = 1; w_valid = 1; aw_address = 2; w_data = 32'h99;
    @(negedge clk);
    aw_valid = 0; w_valid = 0; ar_valid = 1; ar_address = 2;
    @(negedge clk);
    ar_valid = 0;
    chk("pre_rst_b_valid", b_valid, 1);
    chk("pre_rst_ar_busy", ar_ready, 0);
    chk("pre_rst_r_wait", r_valid, 0);
    #1 rst_n = 0;
    #1;
    chk("arst_r_valid", r_valid, 0);
    chk("arst_b_valid", b_valid, 0);
    chk("arst_ar_ready", ar_ready, 1);
    chk("arst_aw_ready", aw_ready, 1);
    chk("arst_w_ready", w_ready, 1);
    chk("arst_z_b_valid", z_b_valid, 0);
    for (int i = 0; i < 16; i++) begin
      dbg_addr = 4'(i); #1;
      chk("arst_mem", dbg_rdata, 0);
      chk("arst_z_mem", z_dbg_rdata, 0);
    end
    model_clr();
    @(negedge clk);
    rst_n = 1;
    repeat (5) begin
      @(negedge clk);
      chk("post_rst_r_valid", r_valid, 0);
      chk("post_rst_b_valid", b_valid, 0);
      chk("post_rst_z_r_valid", z_r_valid, 0);
    end
    check_read(4'd2, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sort_mem_responder.md
Name: sort_mem_responder

Overview:
- Memory-side responder for the sorting engine's five-channel memory interface (AR/R read, AW/W/B write).
- Holds a register-file memory and answers read and write transactions with valid/ready handshakes and programmable read latency.
- Used as the memory model in system benches and as the on-chip scratch memory in integration builds.
- A backdoor debug port preloads and inspects contents without touching the bus.

Parameters:
- ADDR_WDTH, 4, address width of AR/AW and the debug port.
- DATA_WDTH, 32, data word width.
- RESP_WDTH, 1, response width. Value 0 = OKAY, 1 = ERROR; wider responses zero-extend.
- MEM_DEPTH, 16, number of implemented words. Must be ≤ 2**ADDR_WDTH.
- RD_LAT, 1, idle cycles between the AR handshake and r_valid assertion. Range 0..15.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ar_valid  in  1  read address valid
- ar_ready  out  1  read address accepted
- ar_address  in  ADDR_WDTH  read word address
- r_valid  out  1  read data valid
- r_ready  in  1  read data taken
- r_data  out  DATA_WDTH  read data
- r_resp  out  RESP_WDTH  read response
- aw_valid  in  1  write address valid
- aw_ready  out  1  write address accepted
- aw_address  in  ADDR_WDTH  write word address
- w_valid  in  1  write data valid
- w_ready  out  1  write data accepted
- w_data  in  DATA_WDTH  write data
- b_valid  out  1  write response valid
- b_ready  in  1  write response taken
- b_resp  out  RESP_WDTH  write response
- dbg_we  in  1  backdoor write enable
- dbg_addr  in  ADDR_WDTH  backdoor address
- dbg_wdata  in  DATA_WDTH  backdoor write data
- dbg_rdata  out  DATA_WDTH  combinational mem[dbg_addr]; 0 if out of range

Behaviour:
- Reset:
  - Both FSMs go to idle.
  - ar_ready=1, aw_ready=1, w_ready=1; r_valid=0, b_valid=0; r_data=0, r_resp=0, b_resp=0.
  - All memory words cleared to 0.
  - Any outstanding transaction is dropped and produces no response after reset release.
- Read FSM, states R_IDLE, R_WAIT, R_RESP:
  - ar_ready=1 only in R_IDLE. A handshake (ar_valid&ar_ready) latches ar_address.
  - RD_LAT=0: handshake goes straight to R_RESP.
  - RD_LAT>0: handshake goes to R_WAIT with counter=RD_LAT-1. The counter decrements each cycle; at 0 the FSM moves to R_RESP.
  - First r_valid is exactly RD_LAT+1 cycles after the handshake edge.
  - On entry to R_RESP, r_data and r_resp are registered. In-range address: mem[addr], resp 0. Address ≥ MEM_DEPTH: data 0, resp 1.
  - r_valid, r_data and r_resp stay stable until r_ready. The handshake returns the FSM to R_IDLE.
  - Back-to-back reads therefore need at least one R_IDLE cycle.
- Write FSM, states W_COLLECT, W_COMMIT, W_RESP:
  - In W_COLLECT, AW and W are accepted independently and in either order. Each is captured once, after which its ready drops.
  - Simultaneous AW and W in the same cycle is legal.
  - When both are held, the FSM moves to W_COMMIT for one cycle. In-range address: the memory write happens on that cycle's closing edge, b_resp=0. Out of range: no write, b_resp=1.
  - W_RESP: b_valid=1 until b_ready. The handshake returns to W_COLLECT with aw_ready and w_ready both 1.
- Collisions and ordering:
  - A read sample and a write commit on the same edge at the same address return the old data.
  - A dbg_we write and a bus commit on the same edge at the same address: the bus write wins.
  - dbg_we is ignored for addresses ≥ MEM_DEPTH.
  - Read and write paths are fully independent; no ordering is enforced between them.
- Width rules:
  - Out-of-range compare is unsigned on the full ADDR_WDTH.
  - When MEM_DEPTH = 2**ADDR_WDTH, no address errors.
- Inputs are sampled only in states where the matching ready is high; changes elsewhere are ignored.

Decomposition:
- Package sort_mem_pkg: RESP_OKAY and RESP_ERROR constants, read and write state encodings, RD_LAT counter width (4).
- Sub-module sort_mem_storage: MEM_DEPTH×DATA_WDTH register file.
  - Async clear; one bus write port plus one backdoor write port, with bus priority.
  - Two combinational read ports (bus read, debug read).
  - The FSMs stay in sort_mem_responder.

Test Plan:
- Reset, then dbg preload mem[3]=0x0000_00A5; AR addr 3 with r_ready=1, RD_LAT=1 -> ar_ready is 0 for 2 cycles; r_valid rises 2 cycles after the handshake with r_data=0xA5, r_resp=0.
- W handshake 0xDEAD_BEEF first, AW addr 5 two cycles later; b_ready held 0 for 3 cycles -> w_ready low after the first handshake; b_valid stays high and stable; dbg_rdata@5=0xDEADBEEF after W_COMMIT.
- MEM_DEPTH=12: read addr 14 -> r_data=0, r_resp=1; write addr 13 -> b_resp=1, memory unchanged.
- r_ready held 0 for 4 cycles after r_valid -> r_data and r_resp stable; no new AR accepted (ar_ready=0) until the R handshake.
- Read and write of addr 7 committing on the same edge (old value 0x11, new 0x22) -> read returns 0x11; a subsequent read returns 0x22.
- rst_n pulsed low in R_WAIT and W_RESP -> r_valid and b_valid 0 immediately; all readies 1; all memory words 0; no stale response after release.
